uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance between NREQ independent byte sources using round-robin arbitration. It latches the winning requester's byte and drives the uart_tx txdata/tx_start inputs. It watches tx_busy to sequence each byte and returns a one-cycle accept pulse to the winning requester. It sits in the clk60 domain between the producers and uart_tx. A start watchdog recovers the arbiter if uart_tx never acknowledges a start.

Parameters:
NREQ, 4, number of requesters (2..8)
START_TIMEOUT, 16, clk cycles to wait in ISSUE for tx_busy to rise before aborting (>=2)

Ports:
clk  in  1  system clock (clk60)
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester byte available; level, held until req_ready
req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  out  NREQ  one-cycle pulse: byte of requester i consumed
txdata  out  8  byte to uart_tx
tx_start  out  1  start request to uart_tx; level, held until tx_busy seen high
tx_busy  in  1  uart_tx busy flag
grant  out  NREQ  one-hot current owner; all-zero in IDLE
arb_busy  out  1  high in any state other than IDLE
err_timeout  out  1  one-cycle pulse when the start watchdog fires

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; txdata=0; tx_start=0; req_ready=0; grant=0; err_timeout=0; counter=0; last-grant pointer=NREQ-1, so requester 0 has highest priority first.
- All outputs are registered.
- IDLE:
  - If tx_busy=0 and any req_valid is set, pick the first set bit scanning from (last+1) mod NREQ upward, with wrap-around.
  - Next cycle: grant=onehot(winner), txdata=req_data[winner], tx_start=1, go to ISSUE. Latency from req_valid to tx_start is 1 cycle.
  - If tx_busy=1, stay in IDLE; a foreign or residual transmission blocks arbitration.
- ISSUE:
  - Hold tx_start=1 and keep txdata stable; the counter increments each cycle.
  - On tx_busy=1: tx_start=0, pulse req_ready[winner] for 1 cycle, last=winner, go to WAIT.
  - If the counter reaches START_TIMEOUT-1 without tx_busy: tx_start=0, pulse err_timeout, no req_ready, last=winner (do not retry the same requester first), grant=0, return to IDLE.
- WAIT:
  - Remain until tx_busy=0, then grant=0 and return to IDLE.
  - The earliest next grant comes the cycle after IDLE is entered, so back-to-back bytes have a 2-cycle gap after tx_busy falls.
- req_data is sampled only at grant. Later changes, or req_valid dropping while in ISSUE, do not affect the byte in flight. The byte is still sent and req_ready still pulses.
- A requester must deassert req_valid, or present its next byte, in the cycle after req_ready. If it holds valid, it is simply treated as a new request.
- With a single requester continuously valid, it is granted every byte. With all valid, the order is 0,1,2,3,0,...
- Counter width is clog2(START_TIMEOUT). It is cleared on entry to ISSUE.
- Reset mid-transfer forces IDLE immediately with tx_start=0. uart_tx has its own reset.

Optional Feature:
UART_ARB_LOCK_EN.
- Defined:
  - Adds input req_last [NREQ-1:0], sampled with req_data at grant.
  - If the latched req_last=0, the owner keeps the grant for its next byte: WAIT returns to IDLE with the owner forced as winner, provided its req_valid=1.
  - If the owner's req_valid=0 when WAIT exits, the lock is dropped and normal round-robin applies.
  - A timeout always drops the lock.
  - This keeps multi-byte packets contiguous.
- Undefined: no req_last port; every byte is arbitrated independently.

Test Plan:
1. Reset release with req_valid=4'b0000, tx_busy=0 -> all outputs 0, arb_busy=0, grant=0 for 20 cycles.
2. req_valid=4'b1111 held, data 0x41/0x42/0x43/0x44, uart_tx model raising tx_busy 2 cycles after tx_start and holding it 600 cycles -> txdata sequence 0x41,0x42,0x43,0x44,0x41; exactly one req_ready pulse per byte to the matching index.
3. Only requester 2 valid (0x5A), then requester 1 asserts mid-WAIT -> 0x5A sent first. Requester 1 is granted next, the cycle after IDLE is entered following tx_busy fall.
4. Model never raises tx_busy, START_TIMEOUT=16, requester 0 valid -> tx_start high exactly 16 cycles, err_timeout pulses once, no req_ready; requester 1 (if valid) is served next.
5. rst asserted during WAIT -> tx_start=0, grant=0, arb_busy=0 immediately (asynchronously); normal arbitration after release starts at requester 0.
6. UART_ARB_LOCK_EN: requester 1 sends 3 bytes with req_last=0,0,1 while requester 0 is continuously valid -> the 3 bytes of requester 1 are sent contiguously, then requester 0 is granted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, uart_tx_arbiter and a shared uart_tx.
// req_last is present only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_last;
`endif
  logic [7:0]        txdata;
  logic              tx_start;
  logic              tx_busy;
  logic [NREQ-1:0]   grant;
  logic              arb_busy;
  logic              err_timeout;

  // Producer / uart_tx side.
  modport master (
    output req_valid, req_data, tx_busy,
`ifdef UART_ARB_LOCK_EN
    output req_last,
`endif
    input  req_ready, txdata, tx_start, grant, arb_busy, err_timeout
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, tx_busy,
`ifdef UART_ARB_LOCK_EN
    input  req_last,
`endif
    output req_ready, txdata, tx_start, grant, arb_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte sources, with a start watchdog.
// Optional packet lock (owner keeps the grant until req_last) enabled by UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(START_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       txdata_q, txdata_d;
  logic             tx_start_q, tx_start_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             arb_busy_q, arb_busy_d;
  logic             err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win_q, win_d;

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] win_sel;
  logic             rr_found;
  logic             lock_hit;
  logic             grant_now;
  logic             timeout_hit;

  // Scan from the requester after the last winner, wrapping at NREQ-1.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = last_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_RST) ? '0 : cand + IDX_W'(1);
      if (!rr_found && bus.req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign win_sel     = lock_hit ? win_q : rr_idx;
  assign grant_now   = (state_q == S_IDLE) && !bus.tx_busy && rr_found;
  assign timeout_hit = (cnt_q == CNT_MAX);

`ifdef UART_ARB_LOCK_EN
  logic pkt_last_q, pkt_last_d;
  logic lock_q, lock_d;

  // Lock survives WAIT only if the packet is unfinished and the owner still has a byte.
  always_comb begin
    pkt_last_d = pkt_last_q;
    lock_d     = lock_q;
    if (grant_now) begin
      pkt_last_d = bus.req_last[win_sel];
      lock_d     = 1'b0;
    end else if (state_q == S_WAIT && !bus.tx_busy) begin
      lock_d = !pkt_last_q && bus.req_valid[win_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_last_q <= 1'b1;
      lock_q     <= 1'b0;
    end else begin
      pkt_last_q <= pkt_last_d;
      lock_q     <= lock_d;
    end
  end

  assign lock_hit = lock_q && bus.req_valid[win_q];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_now) state_d = S_ISSUE;
      S_ISSUE: begin
        if (bus.tx_busy)      state_d = S_WAIT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WAIT:  if (!bus.tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txdata_d      = txdata_q;
    tx_start_d    = tx_start_q;
    grant_d       = grant_q;
    req_ready_d   = '0;
    err_timeout_d = 1'b0;
    cnt_d         = cnt_q;
    last_d        = last_q;
    win_d         = win_q;
    arb_busy_d    = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (grant_now) begin
          grant_d    = NREQ'(1) << win_sel;
          txdata_d   = bus.req_data[{win_sel, 3'b000} +: 8];
          tx_start_d = 1'b1;
          cnt_d      = '0;
          win_d      = win_sel;
        end
      end
      S_ISSUE: begin
        if (bus.tx_busy) begin
          tx_start_d  = 1'b0;
          req_ready_d = grant_q;
          last_d      = win_q;
        end else if (timeout_hit) begin
          // Winner still becomes "last" so a dead requester cannot starve the rest.
          tx_start_d    = 1'b0;
          err_timeout_d = 1'b1;
          grant_d       = '0;
          last_d        = win_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!bus.tx_busy) grant_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      txdata_q      <= '0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      grant_q       <= '0;
      arb_busy_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
      last_q        <= LAST_RST;
      win_q         <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q       <= state_d;
      txdata_q      <= txdata_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      grant_q       <= grant_d;
      arb_busy_q    <= arb_busy_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      win_q         <= win_d;
    end
  end

  assign bus.txdata      = txdata_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.grant       = grant_q;
  assign bus.arb_busy    = arb_busy_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based requesters, a uart_tx busy model
// and a round-robin reference model computed from the arbitration rules.
module tb_uart_tx_arbiter;
  localparam int NREQ          = 4;
  localparam int START_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } ent_t;

  ent_t            req_q [NREQ][$];
  int              exp_idx [$];
  logic [7:0]      exp_data [$];
  logic [NREQ-1:0] sent_grant [$];
  logic [7:0]      sent_data [$];
  int              ready_idx [$];

  int checks     = 0;
  int failures   = 0;
  int err_count  = 0;
  int model_last = NREQ - 1;
  bit auto_mode  = 1'b0;
  bit never_busy = 1'b0;
  int rise_lo = 2, rise_hi = 2, busy_lo = 600, busy_hi = 600;
  int rise_cnt = 0, busy_cnt = 0;

  // uart_tx model: tx_busy rises some cycles after tx_start, stays high busy_len cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
      end else if (rise_cnt > 0) begin
        rise_cnt--;
        if (rise_cnt == 0) begin
          bus.tx_busy = 1'b1;
          busy_cnt    = $urandom_range(busy_hi, busy_lo);
          sent_grant.push_back(bus.grant);
          sent_data.push_back(bus.txdata);
        end
      end else if (bus.tx_start === 1'b1 && !never_busy && bus.tx_busy === 1'b0) begin
        rise_cnt = $urandom_range(rise_hi, rise_lo);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (v[i] === 1'b1) r = i;
    return r;
  endfunction

  task automatic push_byte(input int i, input logic [7:0] d, input logic l);
    ent_t e;
    e.last = l;
    e.data = d;
    req_q[i].push_back(e);
  endtask

  task automatic drive_from_queues();
    ent_t e;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = (req_q[i].size() != 0);
      if (req_q[i].size() != 0) begin
        e = req_q[i][0];
        bus.req_data[8*i +: 8] = e.data;
`ifdef UART_ARB_LOCK_EN
        bus.req_last[i] = e.last;
`endif
      end
    end
  endtask

  // One clock: sample at the falling edge, log accept pulses, advance requester queues.
  task automatic cycle();
    ent_t e;
    int   w;
    @(negedge clk);
    if (bus.err_timeout === 1'b1) err_count++;
    if (bus.req_ready !== '0) begin
      check("ready_matches_grant", 64'(bus.req_ready), 64'(bus.grant));
      w = onehot_idx(bus.req_ready);
      ready_idx.push_back(w);
      if (auto_mode && w >= 0 && req_q[w].size() != 0) begin
        e = req_q[w].pop_front();
        drive_from_queues();
      end
    end
  endtask

  // Reference: every pending byte is granted in round-robin order from the last winner;
  // with the lock feature, an unfinished packet keeps its owner while it has bytes left.
  function automatic void build_expected();
    ent_t m [NREQ][$];
    ent_t e;
    int   last  = model_last;
    int   owner = -1;
    int   left  = 0;
    int   w;
    exp_idx.delete();
    exp_data.delete();
    for (int i = 0; i < NREQ; i++) begin
      m[i] = req_q[i];
      left += m[i].size();
    end
    while (left > 0) begin
      w = -1;
      if (owner >= 0 && m[owner].size() != 0) w = owner;
      else
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && m[(last + k) % NREQ].size() != 0) w = (last + k) % NREQ;
      e = m[w].pop_front();
      exp_idx.push_back(w);
      exp_data.push_back(e.data);
      last = w;
      left--;
`ifdef UART_ARB_LOCK_EN
      owner = e.last ? -1 : w;
`endif
    end
    model_last = last;
  endfunction

  task automatic run_queues(input string tag);
    int n_bytes;
    int budget;
    logic [NREQ-1:0] oh;
    build_expected();
    n_bytes = exp_data.size();
    budget  = n_bytes * (busy_hi + rise_hi + 8) + 40;
    sent_grant.delete();
    sent_data.delete();
    ready_idx.delete();
    auto_mode = 1'b1;
    drive_from_queues();
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (ready_idx.size() >= n_bytes && sent_data.size() >= n_bytes &&
          bus.arb_busy === 1'b0 && bus.tx_busy === 1'b0) break;
    end
    auto_mode     = 1'b0;
    bus.req_valid = '0;
    check({tag, "_sent_count"}, 64'(sent_data.size()), 64'(n_bytes));
    check({tag, "_ready_count"}, 64'(ready_idx.size()), 64'(n_bytes));
    for (int i = 0; i < n_bytes; i++) begin
      oh = '0;
      oh[exp_idx[i]] = 1'b1;
      if (i < sent_data.size()) begin
        check($sformatf("%s_grant[%0d]", tag, i), 64'(sent_grant[i]), 64'(oh));
        check($sformatf("%s_txdata[%0d]", tag, i), 64'(sent_data[i]), 64'(exp_data[i]));
      end
      if (i < ready_idx.size())
        check($sformatf("%s_ready[%0d]", tag, i), 64'(ready_idx[i]), 64'(exp_idx[i]));
    end
  endtask

  task automatic wait_ready(input string tag, input int idx);
    ready_idx.delete();
    for (int n = 0; n < 60 && ready_idx.size() == 0; n++) cycle();
    check({tag, "_ready_seen"}, 64'(ready_idx.size()), 64'd1);
    if (ready_idx.size() != 0) check({tag, "_ready_idx"}, 64'(ready_idx[0]), 64'(idx));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (n < 1000 && (bus.arb_busy !== 1'b0 || bus.tx_busy !== 1'b0)) begin
      cycle();
      n++;
    end
    check({tag, "_idle"}, 64'({bus.arb_busy, bus.tx_busy}), 64'd0);
  endtask

  int hi;
  int err0;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef UART_ARB_LOCK_EN
    bus.req_last  = '1;
`endif

    // Reset release with nothing pending: everything stays quiet.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("reset_idle", 64'({bus.txdata, bus.tx_start, bus.req_ready, bus.grant,
                               bus.arb_busy, bus.err_timeout}), 64'd0);
    end

    // All four requesters valid, requester 0 holding valid for a second byte.
    push_byte(0, 8'h41, 1'b1);
    push_byte(0, 8'h41, 1'b1);
    push_byte(1, 8'h42, 1'b1);
    push_byte(2, 8'h43, 1'b1);
    push_byte(3, 8'h44, 1'b1);
    run_queues("rr_all");

    // Single requester, then a second one appears while the first byte is on the wire.
    rise_lo = 2; rise_hi = 2; busy_lo = 30; busy_hi = 30;
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'h5A;
    cycle();
    check("lat_tx_start", 64'(bus.tx_start), 64'd1);
    check("lat_grant", 64'(bus.grant), 64'(4'b0100));
    check("lat_txdata", 64'(bus.txdata), 64'h5A);
    wait_ready("single", 2);
    bus.req_valid = 4'b0010;
    bus.req_data[15:8] = 8'h33;
    for (int n = 0; n < 100 && bus.tx_busy !== 1'b0; n++) cycle();
    check("wait_busy_fell", 64'(bus.tx_busy), 64'd0);
    check("wait_grant_held", 64'({bus.grant, bus.arb_busy}), 64'({4'b0100, 1'b1}));
    cycle();
    check("idle_gap", 64'({bus.grant, bus.arb_busy, bus.tx_start}), 64'd0);
    cycle();
    check("next_grant", 64'({bus.grant, bus.tx_start, bus.txdata}),
          64'({4'b0010, 1'b1, 8'h33}));
    wait_ready("second", 1);
    bus.req_valid = '0;
    wait_idle("second");
    model_last = 1;

    // uart_tx never acknowledges: each start is abandoned after START_TIMEOUT cycles.
    never_busy = 1'b1;
    err0 = err_count;
    ready_idx.delete();
    bus.req_valid = 4'b0011;
    bus.req_data[7:0]  = 8'h10;
    bus.req_data[15:8] = 8'h11;
    cycle();
    check("to_first_grant", 64'({bus.grant, bus.tx_start}), 64'({4'b0001, 1'b1}));
    hi = 0;
    for (int n = 0; n < 60 && bus.tx_start === 1'b1; n++) begin
      hi++;
      cycle();
    end
    check("to_start_len0", 64'(hi), 64'(START_TIMEOUT));
    check("to_abort_state", 64'({bus.err_timeout, bus.grant, bus.arb_busy}), 64'({1'b1, 4'b0000, 1'b0}));
    bus.req_valid = 4'b0010;
    cycle();
    check("to_next_grant", 64'({bus.grant, bus.tx_start, bus.err_timeout}),
          64'({4'b0010, 1'b1, 1'b0}));
    hi = 0;
    for (int n = 0; n < 60 && bus.tx_start === 1'b1; n++) begin
      hi++;
      cycle();
    end
    bus.req_valid = '0;
    check("to_start_len1", 64'(hi), 64'(START_TIMEOUT));
    check("to_err_pulses", 64'(err_count - err0), 64'd2);
    check("to_no_ready", 64'(ready_idx.size()), 64'd0);
    never_busy = 1'b0;
    cycle();
    model_last = 1;

    // Asynchronous reset in WAIT drops everything without a clock edge.
    busy_lo = 40; busy_hi = 40;
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'h77;
    wait_ready("rst_pre", 2);
    bus.req_valid = '0;
    repeat (3) cycle();
    check("rst_pre_busy", 64'(bus.arb_busy), 64'd1);
    #2 rst = 1'b0;
    #1 check("rst_async", 64'({bus.tx_start, bus.grant, bus.arb_busy, bus.req_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_last = NREQ - 1;
    for (int n = 0; n < 100 && bus.tx_busy !== 1'b0; n++) cycle();
    rise_lo = 1; rise_hi = 3; busy_lo = 2; busy_hi = 6;
    for (int i = 0; i < NREQ; i++) push_byte(i, 8'h80 + 8'(i), 1'b1);
    run_queues("after_rst");

`ifdef UART_ARB_LOCK_EN
    // Three-byte packet from requester 1 stays contiguous despite requester 0 waiting.
    push_byte(0, 8'hA0, 1'b1);
    push_byte(0, 8'hA1, 1'b1);
    push_byte(1, 8'hB0, 1'b0);
    push_byte(1, 8'hB1, 1'b0);
    push_byte(1, 8'hB2, 1'b1);
    run_queues("lock");
`endif

    // Randomized rounds: queue depths, data, packet ends and uart_tx timing.
    for (int r = 0; r < 5; r++) begin
      rise_lo = 1; rise_hi = 6; busy_lo = 1; busy_hi = 12;
      for (int i = 0; i < NREQ; i++) begin
        int len;
        len = (i == r % NREQ) ? $urandom_range(3, 1) : $urandom_range(3, 0);
        for (int b = 0; b < len; b++)
          push_byte(i, 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      end
      run_queues($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
